// File: rtl/rv_exec_unit.sv
// ---------------------------------------------------------------------------
// rv_exec_unit
//
// Multi-cycle RV32I execute stage. It decodes R-type and I-type ALU
// instructions, reads a 32x32 register file, computes the result and writes
// it back. A four-state sequencer (IDLE -> DECODE -> EXEC -> WB) paces the
// work at one instruction every 4 clocks, matching the fetch cadence.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   instr_valid_i  one-cycle strobe: instr_i holds a new instruction
//   instr_i        32-bit instruction word (RV32I encoding)
//   busy_o         high while an instruction is in flight (DECODE..WB)
//   wb_valid_o     one-cycle pulse: a legal instruction retired
//   wb_rd_o        destination register of the last retired instruction
//   wb_data_o      ALU result of the last retired instruction
//   illegal_o      one-cycle pulse in the retire slot for a bad encoding
//   overrun_o      sticky flag: instr_valid_i arrived while busy
//   retired_o      count of legal instructions retired (wraps)
//   dbg_addr_i     register-file debug read address
//   dbg_data_o     combinational read of register dbg_addr_i (x0 reads 0)
//   dbg_state_o    current sequencer state (IDLE=0 DECODE=1 EXEC=2 WB=3)
//
// Handshake: instr_valid_i is a strobe with no back-pressure. A strobe seen
// in IDLE is accepted on that edge; a strobe seen in any other state drops
// the word, leaves the in-flight instruction untouched and sets overrun_o.
// ---------------------------------------------------------------------------
module rv_exec_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        busy_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        illegal_o,
  output logic        overrun_o,
  output logic [31:0] retired_o,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } op_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_e      state_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] r_q;
  op_e         op_q;
  logic        legal_q;
  logic [31:0] rf_q [32];
  logic        wb_valid_q;
  logic        illegal_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        overrun_q;
  logic [31:0] retired_q;

  // Instruction fields, taken from the latched IR.
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm_sext;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imm_sext = {{20{ir_q[31]}}, ir_q[31:20]};

  // Decode: next-state values for op/legality and the operand latches.
  op_e         op_d;
  logic        legal_d;
  logic [31:0] a_d;
  logic [31:0] b_d;

  always_comb begin
    op_d    = OP_ADD;
    legal_d = 1'b0;
    a_d     = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    b_d     = imm_sext;
    if (opcode == OPC_R) begin
      b_d = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
      if (funct7 == F7_ZERO) begin
        legal_d = 1'b1;
        case (funct3)
          3'b000:  op_d = OP_ADD;
          3'b001:  op_d = OP_SLL;
          3'b010:  op_d = OP_SLT;
          3'b011:  op_d = OP_SLTU;
          3'b100:  op_d = OP_XOR;
          3'b101:  op_d = OP_SRL;
          3'b110:  op_d = OP_OR;
          default: op_d = OP_AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        // Only SUB and SRA use the alternate funct7.
        if (funct3 == 3'b000) begin
          op_d    = OP_SUB;
          legal_d = 1'b1;
        end else if (funct3 == 3'b101) begin
          op_d    = OP_SRA;
          legal_d = 1'b1;
        end
      end
    end else if (opcode == OPC_I) begin
      case (funct3)
        3'b000: begin op_d = OP_ADD;  legal_d = 1'b1; end
        3'b010: begin op_d = OP_SLT;  legal_d = 1'b1; end
        3'b011: begin op_d = OP_SLTU; legal_d = 1'b1; end
        3'b100: begin op_d = OP_XOR;  legal_d = 1'b1; end
        3'b110: begin op_d = OP_OR;   legal_d = 1'b1; end
        3'b111: begin op_d = OP_AND;  legal_d = 1'b1; end
        // Shift-immediates: imm[11:5] acts as funct7 and must be exact.
        3'b001: begin
          op_d    = OP_SLL;
          legal_d = (funct7 == F7_ZERO);
        end
        default: begin
          if (funct7 == F7_ZERO) begin
            op_d    = OP_SRL;
            legal_d = 1'b1;
          end else if (funct7 == F7_ALT) begin
            op_d    = OP_SRA;
            legal_d = 1'b1;
          end
        end
      endcase
    end
  end

  // ALU on the latched operands.
  logic [31:0] r_d;
  logic [4:0]  shamt;

  assign shamt = b_q[4:0];

  always_comb begin
    r_d = 32'd0;
    case (op_q)
      OP_ADD:  r_d = a_q + b_q;
      OP_SUB:  r_d = a_q - b_q;
      OP_SLL:  r_d = a_q << shamt;
      OP_SLT:  r_d = {31'd0, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: r_d = {31'd0, (a_q < b_q)};
      OP_XOR:  r_d = a_q ^ b_q;
      OP_SRL:  r_d = a_q >> shamt;
      OP_SRA:  r_d = $signed(a_q) >>> shamt;
      OP_OR:   r_d = a_q | b_q;
      OP_AND:  r_d = a_q & b_q;
      default: r_d = 32'd0;
    endcase
  end

  // Sequencer, register file and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ir_q       <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      r_q        <= 32'd0;
      op_q       <= OP_ADD;
      legal_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      overrun_q  <= 1'b0;
      retired_q  <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      // Retire pulses last exactly one cycle.
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;

      if (state_q != ST_IDLE && instr_valid_i) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (instr_valid_i) begin
            ir_q    <= instr_i;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q     <= a_d;
          b_q     <= b_d;
          op_q    <= op_d;
          legal_q <= legal_d;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          r_q     <= r_d;
          state_q <= ST_WB;
        end
        default: begin
          if (legal_q) begin
            if (rd != 5'd0) begin
              rf_q[rd] <= r_q;
            end
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd;
            wb_data_q  <= r_q;
            retired_q  <= retired_q + 32'd1;
          end else begin
            illegal_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign illegal_o   = illegal_q;
  assign overrun_o   = overrun_q;
  assign retired_o   = retired_q;
  assign dbg_data_o  = (dbg_addr_i == 5'd0) ? 32'd0 : rf_q[dbg_addr_i];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv_exec_unit.sv
`timescale 1ns/1ps
module tb_rv_exec_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        overrun;
  logic [31:0] retired;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  rv_exec_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .busy_o        (busy),
    .wb_valid_o    (wb_valid),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .illegal_o     (illegal),
    .overrun_o     (overrun),
    .retired_o     (retired),
    .dbg_addr_i    (dbg_addr),
    .dbg_data_o    (dbg_data),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: {legal, rd, data}
  logic [37:0] exp_q[$];
  logic [31:0] exp_rf [32];
  logic [31:0] exp_retired;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; the following posedge is E0. Returns at the negedge
  // after E0+3, where the retire pulse must be visible.
  task automatic issue(input logic [31:0] word, input bit legal,
                       input logic [4:0] rd, input logic [31:0] data,
                       input bit inject);
    logic [37:0] e;
    int n;
    instr_valid = 1'b1;
    instr       = word;
    exp_q.push_back({legal, rd, data});
    if (legal) begin
      exp_retired = exp_retired + 32'd1;
      if (rd != 5'd0) exp_rf[rd] = data;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("pulse_cleared", {31'd0, wb_valid | illegal}, 32'd0);
    n = 1;
    while (!(wb_valid | illegal) && n < 8) begin
      if (inject && n == 2) begin
        instr_valid = 1'b1;
        instr       = 32'h00100413; // ADDI x8,x0,1 sampled at E0+2
      end
      @(negedge clk);
      instr_valid = 1'b0;
      n++;
    end
    check("retire_latency", n, 4);
    e = exp_q.pop_front();
    check("wb_valid", {31'd0, wb_valid}, {31'd0, e[37]});
    check("illegal", {31'd0, illegal}, {31'd0, ~e[37]});
    if (e[37]) begin
      check("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
      check("wb_data", wb_data, e[31:0]);
    end
    check("retired", retired, exp_retired);
    check("busy_after_wb", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    dbg_addr    = 5'd0;
    exp_retired = 32'd0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_retired", retired, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort an ADDI x1,x0,5 with reset during EXEC.
    instr_valid = 1'b1;
    instr       = 32'h00500093;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort_in_exec", {30'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_valid) seen++;
    end
    check("abort_no_wb", seen, 0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check("abort_rf_zero", dbg_data, 32'd0);
    end

    // Immediates
    issue(32'h00500093, 1'b1, 5'd1, 32'h00000005, 1'b0); // ADDI x1,x0,5
    issue(32'hFFD00113, 1'b1, 5'd2, 32'hFFFFFFFD, 1'b0); // ADDI x2,x0,-3
    check("retired_two", retired, 32'd2);
    // R-type, back-to-back dependencies on x1/x2
    issue(32'h002081B3, 1'b1, 5'd3, 32'h00000002, 1'b0); // ADD
    issue(32'h40208233, 1'b1, 5'd4, 32'h00000008, 1'b0); // SUB
    issue(32'h001122B3, 1'b1, 5'd5, 32'h00000001, 1'b0); // SLT
    issue(32'h00113333, 1'b1, 5'd6, 32'h00000000, 1'b0); // SLTU
    issue(32'h0020C5B3, 1'b1, 5'd11, 32'hFFFFFFF8, 1'b0); // XOR x11,x1,x2
    issue(32'h00409633, 1'b1, 5'd12, 32'h00000500, 1'b0); // SLL x12,x1,x4
    issue(32'h005156B3, 1'b1, 5'd13, 32'h7FFFFFFE, 1'b0); // SRL x13,x2,x5
    issue(32'h0040E733, 1'b1, 5'd14, 32'h0000000D, 1'b0); // OR x14,x1,x4
    issue(32'h001177B3, 1'b1, 5'd15, 32'h00000005, 1'b0); // AND x15,x2,x1
    issue(32'h40515833, 1'b1, 5'd16, 32'hFFFFFFFE, 1'b0); // SRA x16,x2,x5
    // I-type variants
    issue(32'hFFF12893, 1'b1, 5'd17, 32'h00000001, 1'b0); // SLTI x17,x2,-1
    issue(32'hFFF0B913, 1'b1, 5'd18, 32'h00000001, 1'b0); // SLTIU x18,x1,-1
    issue(32'hFFF0C993, 1'b1, 5'd19, 32'hFFFFFFFA, 1'b0); // XORI x19,x1,-1
    issue(32'h7FF06A13, 1'b1, 5'd20, 32'h000007FF, 1'b0); // ORI x20,x0,0x7ff
    issue(32'h0F017A93, 1'b1, 5'd21, 32'h000000F0, 1'b0); // ANDI x21,x2,0xf0
    issue(32'h01F09B13, 1'b1, 5'd22, 32'h80000000, 1'b0); // SLLI x22,x1,31
    issue(32'h01C15B93, 1'b1, 5'd23, 32'h0000000F, 1'b0); // SRLI x23,x2,28
    // Shift and x0
    issue(32'h40115393, 1'b1, 5'd7, 32'hFFFFFFFE, 1'b0); // SRAI x7,x2,1
    issue(32'h00700013, 1'b1, 5'd0, 32'h00000007, 1'b0); // ADDI x0,x0,7
    dbg_addr = 5'd0;
    #1;
    check("x0_reads_zero", dbg_data, 32'd0);
    // Illegal encodings
    issue(32'h00000000, 1'b0, 5'd0, 32'd0, 1'b0);
    issue(32'h022081B3, 1'b0, 5'd0, 32'd0, 1'b0); // funct7=0000001
    issue(32'h40109B13, 1'b0, 5'd0, 32'd0, 1'b0); // SLLI bad imm[11:5]
    check("overrun_clear", {31'd0, overrun}, 32'd0);
    // Overrun: ADDI x9,x0,9 with a stray ADDI x8 at E0+2
    issue(32'h00900493, 1'b1, 5'd9, 32'h00000009, 1'b1);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    issue(32'hFFF00513, 1'b1, 5'd10, 32'hFFFFFFFF, 1'b0); // accepted at E0+4
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Final register-file sweep against the model
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("rf_x%0d", i), dbg_data, exp_rf[i]);
    end
    check("final_retired", retired, exp_retired);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rv_exec_unit.md
# rv_exec_unit

Multi-cycle execute stage that consumes one 32-bit RV32I instruction word per fetch slot from the instruction-memory stage. It decodes R-type and I-type ALU instructions, reads a 32×32 register file, computes the result, and writes it back. A sequencer paces this work at one instruction per 4 clocks, matching the fetch cadence. The block sits directly downstream of instruction fetch and replaces the bare address-only decode with a complete decode/read/execute/write-back path.

## Interface
- No parameters; datapath fixed at 32 bits, 32 registers.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  one-cycle strobe: instr holds a new instruction
- instr  in  32  instruction word (RV32I encoding)
- busy  out  1  high while an instruction is in flight (states DECODE..WB)
- wb_valid  out  1  one-cycle pulse: a legal instruction retired
- wb_rd  out  5  destination register of the retiring instruction
- wb_data  out  32  ALU result of the retiring instruction
- illegal  out  1  one-cycle pulse in the retire slot for an unsupported encoding
- overrun  out  1  sticky; set when instr_valid arrives while busy
- retired  out  32  count of legal instructions retired
- dbg_addr  in  5  register-file debug read address
- dbg_data  out  32  combinational read of register dbg_addr (x0 reads 0)

## Operation
- FSM states: IDLE → DECODE → EXEC → WB → IDLE.
- IDLE:
  - When instr_valid=1, latch instr into IR and go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - Latch A = rf[rs1].
  - Latch B = rf[rs2] for R-type, or sign-extended imm[11:0] for I-type.
  - Latch the decoded op and legality; go to EXEC.
- EXEC: latch R = ALU(A, B, op); go to WB.
- WB:
  - If the instruction is legal and rd≠0, write rf[rd] = R.
  - If legal, pulse wb_valid (rd=0 included) and increment retired (wraps 0xFFFFFFFF→0).
  - If illegal, pulse illegal instead.
  - Go to IDLE.
- Supported R-type ops (opcode 0110011):
  - ADD, SUB (funct7=0100000, funct3=000)
  - SLL, SLT, SLTU, XOR, SRL
  - SRA (funct7=0100000, funct3=101)
  - OR, AND
- Supported I-type ops (opcode 0010011):
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI
  - SLLI (imm[11:5]=0), SRLI (imm[11:5]=0), SRAI (imm[11:5]=0100000)
- Illegal encodings:
  - Any other opcode.
  - R-type with funct7 ∉ {0, 0100000}, or funct7=0100000 with funct3 ∉ {000, 101}.
  - Shift-immediate with a bad imm[11:5].
  - An illegal instruction never writes rf and never increments retired.
- Arithmetic rules:
  - Add and subtract are mod 2^32.
  - Shift amount is B[4:0].
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned (immediate sign-extended first); result is 0 or 1.
- x0:
  - Hard-wired to 0 on every read path (A, B, dbg_data).
  - Writes to x0 are discarded.
- instr_valid while not in IDLE: the word is dropped, overrun is set, and the in-flight instruction is unaffected. overrun clears only on reset.
- dbg_data reflects a write at the clock edge that performs it (post-edge value).

## Timing
- Reset (asynchronous, any state, including mid-instruction):
  - FSM goes to IDLE; the in-flight instruction is aborted with no write-back.
  - IR, A, B, R and all 32 registers are cleared to 0.
  - Outputs after reset: busy=0, wb_valid=0, illegal=0, wb_rd=0, wb_data=0, overrun=0, retired=0.
- Latency, with edge E0 = the edge that samples instr_valid=1 in IDLE:
  - busy=1 after E0.
  - A/B are latched at E0+1.
  - R is latched at E0+2.
  - The rf write, the wb_valid/illegal pulse, wb_rd/wb_data update and retired increment all take effect at E0+3 and are visible for exactly one cycle.
  - busy=0 after E0+3.
- Throughput: one instruction per 4 cycles. instr_valid sampled at E0+4 is accepted without overrun.
- Back-to-back dependency: the write at E0+3 is visible to the next instruction's DECODE read (earliest at E0+5). No forwarding is needed.
- wb_rd and wb_data hold their last retire values until the next retire.

## Test plan
- Reset: rst_n low mid-EXEC of an ADDI → no write, busy=0, dbg reads 0 for all registers, retired=0.
- Immediates:
  - 0x00500093 (ADDI x1,x0,5), then 0xFFD00113 (ADDI x2,x0,-3), each spaced 4 cycles.
  - Expect x1=5 and x2=0xFFFFFFFD.
  - Each wb_valid pulse occurs 3 edges after acceptance; retired=2.
- R-type, continuing from the previous state:
  - 0x002081B3 (ADD x3,x1,x2) → 2.
  - 0x40208233 (SUB x4,x1,x2) → 8.
  - 0x001122B3 (SLT x5,x2,x1) → 1.
  - 0x00113333 (SLTU x6,x2,x1) → 0.
- Shift and x0:
  - 0x40115393 (SRAI x7,x2,1) → 0xFFFFFFFE.
  - 0x00700013 (ADDI x0,x0,7) → wb_valid with wb_rd=0, wb_data=7, dbg x0=0.
- Illegal: 0x00000000 → illegal pulses once, wb_valid=0, retired unchanged, no register changes.
- Overrun: instr_valid at E0+2 carrying ADDI x8,x0,1 → overrun=1 and x8 stays 0. The first instruction retires normally, and a strobe at E0+4 is accepted.
